// File: rtl/tx_fdt_scheduler_if.sv
// tx_fdt_scheduler_if
//   Groups the byte-wide response source side and the bit-wide tx side of the
//   scheduler.
//   in_data[7:0] / in_bits[2:0] / in_last / in_valid / in_ready : byte stream
//   out_data / out_valid / out_req                              : bit stream to tx
//   The scheduler owns the tx bit stream, so it uses the master modport. The
//   application source together with the tx encoder uses the slave modport.
interface tx_fdt_scheduler_if;
    logic [7:0] in_data;
    logic [2:0] in_bits;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic       out_data;
    logic       out_valid;
    logic       out_req;

    modport master (
        input  in_data, in_bits, in_last, in_valid, out_req,
        output in_ready, out_data, out_valid
    );

    modport slave (
        output in_data, in_bits, in_last, in_valid, out_req,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/tx_fdt_scheduler.sv
// tx_fdt_scheduler
//   Times the PICC frame delay from the end of the reader frame, launches the
//   response on the 128-cycle bit grid, and serialises response bytes LSB first
//   into the tx bit encoder.
// Ports
//   clk, rst_n          : carrier clock, asynchronous active-low reset
//   rx_eoc, rx_last_bit : end-of-reader-frame pulse and value of its last bit
//   bus (master)        : byte input (in_*) and tx bit output (out_*)
//   busy                : state is not idle
//   timeout             : one-cycle pulse, response abandoned after late slots ran out
//   underrun            : one-cycle pulse, next byte was not available at a byte boundary
// Configuration
//   TX_FDT_SCHED_PARITY_EN : when defined, an odd-parity bit follows each full byte.
module tx_fdt_scheduler #(
    parameter int unsigned FDT_N         = 9,
    parameter int unsigned TX_LATENCY    = 3,
    parameter int unsigned TIMEOUT_SLOTS = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_eoc,
    input  logic               rx_last_bit,
    tx_fdt_scheduler_if.master bus,
    output logic               busy,
    output logic               timeout,
    output logic               underrun
);

    localparam logic [15:0] TargetLast1  = 16'(FDT_N * 128 + 84 - TX_LATENCY);
    localparam logic [15:0] TargetLast0  = 16'(FDT_N * 128 + 20 - TX_LATENCY);
    localparam logic [7:0]  TimeoutSlots = 8'(TIMEOUT_SLOTS);

    typedef enum logic [1:0] {StIdle, StCount, StLate, StSend} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc, target;
    logic [6:0]  phase_q, phase_d, phase_inc;
    logic [7:0]  slot_q, slot_d, slot_inc;
    logic        rx_last_q, rx_last_d;
    logic [8:0]  sr_q, sr_d, load_sr;
    logic [3:0]  bit_cnt_q, bit_cnt_d, load_cnt;
    logic        byte_last_q, byte_last_d;
    logic        out_valid_q, out_valid_d;
    logic        timeout_q, timeout_d;
    logic        underrun_q, underrun_d;
    logic        full_byte, load, finish, in_ready;

    // The incremented value is what gets compared, so the cycle after rx_eoc
    // already counts as 1 and the launch cycle lands exactly on cycle T. The
    // same applies to the phase counter: grid slots fall on T + 128*k.
    assign cnt_inc   = cnt_q + 16'd1;
    assign phase_inc = phase_q + 7'd1;
    assign slot_inc  = slot_q + 8'd1;
    assign target    = rx_last_q ? TargetLast1 : TargetLast0;

    // Shift register image and bit count for the byte currently on in_data.
    always_comb begin
        full_byte = !bus.in_last || (bus.in_bits == 3'd0);
        load_sr   = {1'b0, bus.in_data};
        load_cnt  = full_byte ? 4'd8 : {1'b0, bus.in_bits};
`ifdef TX_FDT_SCHED_PARITY_EN
        if (full_byte) begin
            load_sr[8] = ~^bus.in_data;
            load_cnt   = 4'd9;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        slot_d      = slot_q;
        rx_last_d   = rx_last_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        byte_last_d = byte_last_q;
        out_valid_d = out_valid_q;
        timeout_d   = 1'b0;
        underrun_d  = 1'b0;
        load        = 1'b0;
        finish      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_eoc) begin
                    rx_last_d = rx_last_bit;
                    cnt_d     = 16'd0;
                    state_d   = StCount;
                end
            end
            StCount: begin
                if (rx_eoc) begin
                    rx_last_d = rx_last_bit;
                    cnt_d     = 16'd0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == target) begin
                        if (bus.in_valid) begin
                            load = 1'b1;
                        end else begin
                            phase_d = 7'd0;
                            slot_d  = 8'd0;
                            state_d = StLate;
                        end
                    end
                end
            end
            StLate: begin
                if (rx_eoc) begin
                    rx_last_d = rx_last_bit;
                    cnt_d     = 16'd0;
                    phase_d   = 7'd0;
                    slot_d    = 8'd0;
                    state_d   = StCount;
                end else begin
                    phase_d = phase_inc;
                    if (phase_inc == 7'd0) begin
                        slot_d = slot_inc;
                        if (bus.in_valid) begin
                            load = 1'b1;
                        end else if (slot_inc == TimeoutSlots) begin
                            timeout_d = 1'b1;
                            phase_d   = 7'd0;
                            slot_d    = 8'd0;
                            state_d   = StIdle;
                        end
                    end
                end
            end
            StSend: begin
                if (bus.out_req) begin
                    if (bit_cnt_q == 4'd1) begin
                        if (byte_last_q) begin
                            finish = 1'b1;
                        end else if (bus.in_valid) begin
                            load = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                            finish     = 1'b1;
                        end
                    end else begin
                        sr_d      = sr_q >> 1;
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            sr_d        = load_sr;
            bit_cnt_d   = load_cnt;
            byte_last_d = bus.in_last;
            out_valid_d = 1'b1;
            state_d     = StSend;
        end

        // Clearing the shift register keeps out_data low between frames.
        if (finish) begin
            sr_d        = 9'd0;
            bit_cnt_d   = 4'd0;
            byte_last_d = 1'b0;
            out_valid_d = 1'b0;
            state_d     = StIdle;
        end

        in_ready = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            phase_q     <= 7'd0;
            slot_q      <= 8'd0;
            rx_last_q   <= 1'b0;
            sr_q        <= 9'd0;
            bit_cnt_q   <= 4'd0;
            byte_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            slot_q      <= slot_d;
            rx_last_q   <= rx_last_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_last_q <= byte_last_d;
            out_valid_q <= out_valid_d;
            timeout_q   <= timeout_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = sr_q[0];
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != StIdle);
    assign timeout       = timeout_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_tx_fdt_scheduler.sv
// tb_tx_fdt_scheduler
//   Scoreboard bench: expected tx bits are queued when a byte is accepted and
//   popped when the tx model consumes a bit with out_req.
module tb_tx_fdt_scheduler;

    localparam int FdtN     = 9;
    localparam int TxLat    = 3;
    localparam int TmoSlots = 255;
    localparam int T1       = FdtN * 128 + 84 - TxLat;  // 1233
    localparam int T0       = FdtN * 128 + 20 - TxLat;  // 1169
`ifdef TX_FDT_SCHED_PARITY_EN
    localparam int ParBit = 1;
`else
    localparam int ParBit = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic rx_eoc;
    logic rx_last_bit;
    logic busy;
    logic timeout;
    logic underrun;

    tx_fdt_scheduler_if bus ();

    tx_fdt_scheduler #(
        .FDT_N        (FdtN),
        .TX_LATENCY   (TxLat),
        .TIMEOUT_SLOTS(TmoSlots)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_eoc     (rx_eoc),
        .rx_last_bit(rx_last_bit),
        .bus        (bus),
        .busy       (busy),
        .timeout    (timeout),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Frame contents and results of the last run_frame call.
    logic [7:0]  fd [4];
    logic [2:0]  fb;
    int          fn;
    bit          exp_q [$];
    logic [63:0] stream;
    int          r_rise, r_tmo, r_under, r_bits;

    task automatic push_byte(input int idx);
        int nb;
        nb = (idx == fn - 1 && fb != 3'd0) ? int'(fb) : 8;
        for (int i = 0; i < nb; i++) exp_q.push_back(fd[idx][i]);
        if (ParBit == 1 && nb == 8) exp_q.push_back(~^fd[idx]);
    endtask

    // Cycle 0 is the rx_eoc cycle; every drive and sample happens at the negedge.
    task automatic run_frame(input bit last, input int vbytes, input int vdelay,
                             input int ivl, input int eoc2_t, input bit eoc2_last,
                             input int budget);
        int idx;
        bit done;
        bit b;
        idx = 0;
        done = 1'b0;
        exp_q.delete();
        stream  = '0;
        r_rise  = -1;
        r_tmo   = -1;
        r_under = 0;
        r_bits  = 0;
        for (int t = 0; t < budget && !done; t++) begin
            @(negedge clk);
            if (bus.out_valid && r_rise < 0) r_rise = t;
            if (underrun) r_under++;
            if (timeout) begin
                r_tmo = t;
                check("busy_after_timeout", busy, 0);
                done = 1'b1;
            end
            if (r_rise >= 0 && !bus.out_valid) done = 1'b1;
            rx_eoc       = (t == 0) || (t == eoc2_t);
            rx_last_bit  = (t == eoc2_t) ? eoc2_last : last;
            bus.in_valid = (idx < vbytes) && (idx < fn) && (t >= vdelay);
            bus.in_data  = (idx < fn) ? fd[idx] : 8'h00;
            bus.in_last  = (idx == fn - 1);
            bus.in_bits  = (idx == fn - 1) ? fb : 3'd0;
            bus.out_req  = bus.out_valid && (r_rise >= 0) && ((t - r_rise) % ivl == ivl - 1);
            if (bus.out_req) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("extra_bit%0d", r_bits), 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check($sformatf("bit%0d", r_bits), bus.out_data, b);
                end
                stream = {stream[62:0], bus.out_data};
                r_bits++;
            end
            #1;
            if (bus.in_ready) begin
                push_byte(idx);
                idx++;
            end
        end
        if (!done) check("frame_done_in_budget", 0, 1);
        @(negedge clk);
        rx_eoc       = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_req  = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        rx_eoc       = 1'b0;
        rx_last_bit  = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_bits  = 3'd0;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_req  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_underrun", underrun, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 3-byte frame, tx requests a bit every 128 cycles.
        fd[0] = 8'hA5; fd[1] = 8'h01; fd[2] = 8'hFF; fn = 3; fb = 3'd0;
        run_frame(1'b1, 3, 0, 128, -1, 1'b0, 8000);
        check("rise_last1", r_rise, 1234);
        check("bits_3byte", r_bits, 24 + 3 * ParBit);
        check("queue_empty_3byte", exp_q.size(), 0);
        check("underrun_3byte", r_under, 0);
`ifdef TX_FDT_SCHED_PARITY_EN
        check("stream_3byte", stream[26:0], 27'b101001011_100000000_111111111);
`else
        check("stream_3byte", stream[23:0], 24'b10100101_10000000_11111111);
`endif

        // Last reader bit 0 gives the shorter delay.
        fd[0] = 8'h3C; fn = 1; fb = 3'd0;
        run_frame(1'b0, 1, 0, 4, -1, 1'b0, 3000);
        check("rise_last0", r_rise, 1170);
        check("queue_empty_last0", exp_q.size(), 0);

        // Byte arrives 300 cycles after T: launch on the third late slot.
        fd[0] = 8'h5A; fn = 1; fb = 3'd0;
        run_frame(1'b1, 1, T1 + 300, 4, -1, 1'b0, 3000);
        check("rise_late", r_rise, T1 + 1 + 384);
        check("bits_late", r_bits, 8 + ParBit);

        // Second byte never offered.
        fd[0] = 8'hA5; fd[1] = 8'h77; fn = 2; fb = 3'd0;
        run_frame(1'b1, 1, 0, 4, -1, 1'b0, 3000);
        check("underrun_pulses", r_under, 1);
        check("bits_underrun", r_bits, 8 + ParBit);
        check("queue_empty_underrun", exp_q.size(), 0);

        // No byte at all: abandoned after the last late slot.
        fd[0] = 8'h11; fn = 1; fb = 3'd0;
        run_frame(1'b1, 0, 0, 4, -1, 1'b0, T1 + TmoSlots * 128 + 50);
        check("timeout_cycle", r_tmo, T1 + TmoSlots * 128 + 1);
        check("no_launch_on_timeout", r_rise, -1);

        // Second rx_eoc mid-COUNT with the other last-bit value.
        fd[0] = 8'hC3; fn = 1; fb = 3'd0;
        run_frame(1'b1, 1, 0, 4, 500, 1'b0, 3000);
        check("rise_restart", r_rise, 500 + T0 + 1);
        check("queue_empty_restart", exp_q.size(), 0);

        // REQA short frame: 7 bits, never a parity bit.
        fd[0] = 8'h26; fn = 1; fb = 3'd7;
        run_frame(1'b1, 1, 0, 4, -1, 1'b0, 3000);
        check("bits_reqa", r_bits, 7);
        check("stream_reqa", stream[6:0], 7'b0110010);
        check("busy_after_reqa", busy, 0);

        // Reset mid-frame drops every output at once.
        bus.in_data  = 8'hFF;
        bus.in_bits  = 3'd0;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        rx_last_bit  = 1'b1;
        rx_eoc       = 1'b1;
        @(negedge clk);
        rx_eoc = 1'b0;
        for (int i = 0; i < 2000 && !bus.out_valid; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("pre_reset_out_valid", bus.out_valid, 1);
        check("pre_reset_out_data", bus.out_data, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_out_data", bus.out_data, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_pulses", {timeout, underrun}, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tx_fdt_scheduler.md
# tx_fdt_scheduler

Sequences the `tx` bit encoder for a PICC response: it times the frame delay (FDT) from the end of the reader's frame and releases the response on the ISO/IEC 14443-2 bit grid. Once launched, it serialises bytes from the application layer into the `tx` bit stream, LSB first. The block sits between the byte-wide response source and the bit-wide `tx` input.

## Interface
- `FDT_N`, 9: FDT multiplier n; minimum FDT is n·128 + 84 (last rx bit 1) or n·128 + 20 (last rx bit 0) carrier cycles.
- `TX_LATENCY`, 3: cycles from `out_valid` rising to the `tx` SOC appearing on `lm_out`; subtracted from the launch target.
- `TIMEOUT_SLOTS`, 255: late 128-cycle grid slots waited before abandoning the response.
- `clk` in 1: carrier-derived clock, one cycle per carrier period.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_eoc` in 1: single-cycle pulse marking the end of the reader frame.
- `rx_last_bit` in 1: value of the reader frame's last bit; valid with `rx_eoc`.
- `in_data` in 8: response byte, LSB sent first.
- `in_bits` in 3: valid bits in the byte when `in_last`=1 (0 means 8).
- `in_last` in 1: final byte of the response.
- `in_valid` in 1: byte available.
- `in_ready` out 1: byte accepted this cycle (combinational).
- `out_data` out 1: current bit to `tx`.
- `out_valid` out 1: frame in progress; rising edge starts the `tx` SOC, falling edge ends the frame.
- `out_req` in 1: single-cycle pulse from `tx`; the current bit is consumed.
- `busy` out 1: state ≠ IDLE.
- `timeout` out 1: single-cycle pulse; response abandoned.
- `underrun` out 1: single-cycle pulse; `in_valid` was low when the next byte was needed.

## Operation
- IDLE:
  - On `rx_eoc`, latch `rx_last_bit`, clear the 16-bit cycle counter `cnt`, and go to COUNT.
  - Bytes presented in IDLE are not accepted.
- COUNT:
  - `cnt` increments each cycle.
  - Target T = FDT_N·128 + (last ? 84 : 20) − TX_LATENCY.
  - When `cnt` == T: if `in_valid`, launch into SEND; otherwise go to LATE with the 7-bit phase counter = 0.
- LATE:
  - The phase counter increments modulo 128, and the slot counter increments on each wrap.
  - Launch into SEND only on a cycle where phase == 0 and `in_valid`=1.
  - If the slot counter reaches TIMEOUT_SLOTS with no launch, pulse `timeout` and return to IDLE.
- Launch:
  - `in_ready`=1 in that cycle; the byte loads into the shift register, the bit count is loaded, and `in_last`/`in_bits` are latched.
  - `out_valid`=1 from the next cycle.
- SEND:
  - `out_data` = shift register bit 0.
  - On `out_req`, shift and decrement the bit count.
  - On `out_req` when the final bit of a byte is consumed:
    - If the byte was last: `out_valid`←0 and go to IDLE.
    - Else if `in_valid`: `in_ready`=1 and load the next byte the same cycle, with no gap.
    - Else: pulse `underrun`, `out_valid`←0, and go to IDLE.
- `rx_eoc` in COUNT or LATE restarts COUNT with the new `rx_last_bit`. `rx_eoc` in SEND is ignored.
- `in_ready` is never asserted outside a launch or byte-boundary cycle.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `in_ready`=0, `busy`=0, `timeout`=0, `underrun`=0; state IDLE; all counters 0.
- Asynchronous reset mid-frame drops `out_valid` immediately. No pulse is generated.
- With no late slot, `out_valid` rises at cycle T+1 after the `rx_eoc` cycle.
- A late launch occurs at T+1+128·k, with k ≥ 1.
- `out_data` updates in the cycle after `out_req`.
- Counter widths: `cnt` is 16 bits, and T must fit in it. The slot counter is 8 bits.

## Configuration
- `TX_FDT_SCHED_PARITY_EN`:
  - Defined: after each full 8-bit byte, emit an odd-parity bit (~^byte) before the next byte or before the frame ends. A partial last byte (`in_bits`≠0) gets no parity. The byte-boundary logic above then applies after the parity bit.
  - Undefined: raw bits only; no parity bits are inserted.

## Test plan
- `rx_eoc` with `rx_last_bit`=1 and `in_valid` already high (defaults) → `out_valid` rises exactly 1234 cycles later. With `rx_last_bit`=0 → 1170 cycles later.
- `in_valid` asserted 300 cycles after T → launch at T+1+384. `out_valid` is never high before that point.
- 3-byte frame 0xA5,0x01,0xFF with `tx` model pulsing `out_req` every 128 cycles → bit stream 10100101 10000000 11111111, plus parity bits 1, 0, 1 after the respective bytes when PARITY_EN is defined.
- `in_valid` dropped before the second byte → `underrun` pulse, `out_valid` falls after bit 8 (or 9 with parity), state IDLE.
- No `in_valid` for 255 slots → `timeout` pulse, `busy`=0. A second `rx_eoc` mid-COUNT → the target is recomputed from the new edge.
- 7-bit frame (REQA 0x26, `in_last`=1, `in_bits`=7) → 7 bits, no parity, `out_valid` falls; reset asserted mid-frame → all outputs 0 immediately.
